eeprom_arbiter: RTL and testbench
=================================

Name: eeprom_arbiter

Overview:
- Shares one serial-EEPROM read/write engine (EEPROM_WR: WR/RD strobes, 11-bit ADDR, 8-bit DATA, one-cycle ACK per completed transfer) between two requesters.
- Arbitration is round-robin. The arbiter sequences one byte transaction at a time, holds WR/RD until ACK, then enforces a post-write recovery gap and a timeout.
- Sits between the system-side masters and the EEPROM engine. The top level owns the DATA tristate, using E_DOE from this block.

Parameters:
- AW, 11, address width (matches the engine's 2K-byte address space).
- DW, 8, data width.
- TIMEOUT, 4095, maximum cycles in ISSUE waiting for E_ACK before abort.
- GAP, 8, idle cycles forced after every completed write (engine/EEPROM write-cycle recovery); 0 disables the gap.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ0, REQ1  in  1 each  transaction request; requester holds it until its DONE pulse.
- WE0, WE1  in  1 each  1 = write, 0 = read.
- ADDR0, ADDR1  in  AW each  byte address.
- WDATA0, WDATA1  in  DW each  write data.
- GNT0, GNT1  out  1 each  high while that requester owns the engine.
- DONE0, DONE1  out  1 each  one-cycle completion pulse.
- RDATA  out  DW  read data; valid in the DONE cycle and held until the next read completes.
- ERR  out  1  high together with DONEx when the transaction timed out.
- E_WR, E_RD  out  1 each  strobes to the engine.
- E_ADDR  out  AW  address to the engine.
- E_DOUT  out  DW  write data to the engine DATA bus.
- E_DOE  out  1  top level drives DATA with E_DOUT when high.
- E_DIN  in  DW  engine DATA bus sampled on read.
- E_ACK  in  1  one-cycle completion from the engine.

Behaviour:
- All outputs are registered. Reset (RESET=0, asynchronous) clears:
  - every output to 0, and RDATA to 0;
  - state to IDLE and both counters to 0;
  - the round-robin pointer to "last = 1", so requester 0 wins first.
- States are one-hot: IDLE, ISSUE, DONE, GAP.
- IDLE:
  - Only one REQ high: grant that requester.
  - Both high: grant the one not served last.
  - On grant, next edge: GNTx=1; latch WEx/ADDRx/WDATAx into E_ADDR/E_DOUT; E_WR=WEx, E_RD=~WEx, E_DOE=WEx; timer cleared; state ISSUE.
  - Latency is REQ sampled -> strobe asserted in 1 cycle.
- ISSUE:
  - E_WR/E_RD, E_ADDR, E_DOUT and E_DOE are held constant; the timer increments each cycle.
  - E_ACK=1: next edge drops E_WR/E_RD; if read, captures E_DIN into RDATA; DONEx=1, ERR=0; state DONE.
  - Timer reaches TIMEOUT without ACK: same exit but RDATA unchanged, ERR=1.
  - ACK in the same cycle as timeout expiry: ACK wins, ERR=0.
- DONE (1 cycle):
  - DONEx and ERR return to 0; GNTx=0; E_DOE=0.
  - Pointer records x as last served.
  - Completed write with GAP>0: load the gap counter and go to GAP. Otherwise go to IDLE.
- GAP:
  - Count down GAP cycles with no grant, then go to IDLE.
  - Requests arriving meanwhile are queued only by their held REQ.
- A REQ dropped mid-transaction is ignored: the transaction completes and DONE is still pulsed.
- E_ACK outside ISSUE is ignored.
- GNT0 and GNT1 are never high together. E_WR and E_RD are never high together.
- A new REQ from the just-served requester in the DONE cycle is legal; if the other requester is also waiting, the other wins.
- Reset mid-ISSUE: strobes drop immediately (asynchronously) and no DONE is issued.

Decomposition:
- Package eeprom_arb_pkg holds:
  - one-hot state constants (4 bits);
  - AW and DW defaults;
  - the counter width, derived from max(TIMEOUT, GAP) as 12 bits.
- Single module; no sub-module needed. The timeout and gap counts share one down/up counter register.

Test Plan:
- REQ0=1, WE0=1, ADDR0=11'h155, WDATA0=8'hA5; E_ACK at cycle 5 -> E_WR=1 with E_ADDR=155/E_DOUT=A5 from cycle 1; DONE0 at cycle 6; no grant for 8 cycles after.
- REQ1 read at ADDR1=11'h7FF, E_DIN=8'h3C at ACK -> E_RD=1, E_DOE=0; RDATA=3C in the DONE1 cycle; ERR=0.
- REQ0 and REQ1 held high continuously, reads, ACK 3 cycles after each strobe -> grants alternate 0,1,0,1; GNTs never overlap.
- Write with E_ACK never asserted, TIMEOUT=16 -> strobe dropped after 16 cycles; DONE0=1 and ERR=1 for 1 cycle; RDATA unchanged.
- E_ACK on the exact timeout cycle -> ERR=0.
- RESET pulsed low during ISSUE -> all outputs 0 asynchronously, no DONE; after release, requester 0 wins a tie.

Source files
------------

// File: rtl/eeprom_arb_pkg.sv
// Shared constants for the EEPROM arbiter: one-hot FSM encoding, bus widths, counter width.
// No latency or backpressure of its own; pure definitions.
package eeprom_arb_pkg;

    localparam int AW_DEF = 11;
    localparam int DW_DEF = 8;

    // Wide enough for max(TIMEOUT=4095, GAP); timeout and gap share this counter.
    localparam int CW = 12;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_DONE  = 4'b0100,
        S_GAP   = 4'b1000
    } arb_state_t;

endpackage

// File: rtl/eeprom_arbiter.sv
// Round-robin arbiter sharing one EEPROM byte engine between two requesters; REQ -> strobe in 1 cycle.
// Strobes held until E_ACK or timeout; requesters wait on held REQ, with a recovery gap after writes.
module eeprom_arbiter
    import eeprom_arb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 4095,
    parameter int GAP     = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          DONE0,
    output logic          DONE1,
    output logic [DW-1:0] RDATA,
    output logic          ERR,
    output logic          E_WR,
    output logic          E_RD,
    output logic [AW-1:0] E_ADDR,
    output logic [DW-1:0] E_DOUT,
    output logic          E_DOE,
    input  logic [DW-1:0] E_DIN,
    input  logic          E_ACK
);

    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP);

    arb_state_t    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          last, last_d;
    logic          gnt0_d, gnt1_d, done0_d, done1_d, err_d;
    logic          wr_d, rd_d, doe_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] dout_d, rdata_d;
    logic          pick1, pick_we;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= S_IDLE;
            cnt    <= '0;
            last   <= 1'b1;
            GNT0   <= 1'b0;
            GNT1   <= 1'b0;
            DONE0  <= 1'b0;
            DONE1  <= 1'b0;
            ERR    <= 1'b0;
            E_WR   <= 1'b0;
            E_RD   <= 1'b0;
            E_DOE  <= 1'b0;
            E_ADDR <= '0;
            E_DOUT <= '0;
            RDATA  <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            last   <= last_d;
            GNT0   <= gnt0_d;
            GNT1   <= gnt1_d;
            DONE0  <= done0_d;
            DONE1  <= done1_d;
            ERR    <= err_d;
            E_WR   <= wr_d;
            E_RD   <= rd_d;
            E_DOE  <= doe_d;
            E_ADDR <= addr_d;
            E_DOUT <= dout_d;
            RDATA  <= rdata_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        last_d  = last;
        gnt0_d  = GNT0;
        gnt1_d  = GNT1;
        done0_d = DONE0;
        done1_d = DONE1;
        err_d   = ERR;
        wr_d    = E_WR;
        rd_d    = E_RD;
        doe_d   = E_DOE;
        addr_d  = E_ADDR;
        dout_d  = E_DOUT;
        rdata_d = RDATA;
        // Requester 1 wins when alone, or on a tie when requester 0 was served last.
        pick1   = REQ1 && (!REQ0 || !last);
        pick_we = pick1 ? WE1 : WE0;

        case (state)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    gnt0_d  = !pick1;
                    gnt1_d  = pick1;
                    addr_d  = pick1 ? ADDR1 : ADDR0;
                    dout_d  = pick1 ? WDATA1 : WDATA0;
                    wr_d    = pick_we;
                    rd_d    = !pick_we;
                    doe_d   = pick_we;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // ACK takes priority over a simultaneous timeout expiry.
                if (E_ACK || cnt == TMO_LAST) begin
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    done0_d = GNT0;
                    done1_d = GNT1;
                    err_d   = !E_ACK;
                    if (E_ACK && E_RD)
                        rdata_d = E_DIN;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_DONE: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                err_d   = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                doe_d   = 1'b0;
                last_d  = GNT1;
                // E_DOE is still up here exactly when the finished transfer was a write.
                if (E_DOE && GAP > 0) begin
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed bench for eeprom_arbiter (TIMEOUT=16, GAP=8); checks strobes, grants, gap, timeout, reset.
module tb_eeprom_arbiter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
    logic [10:0] ADDR0 = '0, ADDR1 = '0;
    logic [7:0]  WDATA0 = '0, WDATA1 = '0;
    logic        GNT0, GNT1, DONE0, DONE1, ERR, E_WR, E_RD, E_DOE;
    logic [7:0]  RDATA, E_DOUT;
    logic [10:0] E_ADDR;
    logic [7:0]  E_DIN = '0;
    logic        E_ACK = 1'b0;

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    int bad;

    eeprom_arbiter #(.AW(11), .DW(8), .TIMEOUT(16), .GAP(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .RDATA(RDATA), .ERR(ERR),
        .E_WR(E_WR), .E_RD(E_RD), .E_ADDR(E_ADDR), .E_DOUT(E_DOUT),
        .E_DOE(E_DOE), .E_DIN(E_DIN), .E_ACK(E_ACK)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if ((GNT0 && GNT1) || (E_WR && E_RD))
            overlap++;
    end

    // {GNT0,GNT1,DONE0,DONE1,ERR,E_WR,E_RD,E_DOE}
    function automatic logic [7:0] outs();
        return {GNT0, GNT1, DONE0, DONE1, ERR, E_WR, E_RD, E_DOE};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        chk("reset_outs", 32'(outs()), 32'h00);
        chk("reset_rdata", 32'(RDATA), 32'h00);
        chk("reset_addr", 32'(E_ADDR), 32'h000);
        RESET = 1'b1;

        // Write from requester 0, ACK in cycle 5
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 11'h155; WDATA0 = 8'hA5;
        tick();
        chk("wr_issue_outs", 32'(outs()), 32'h85);
        chk("wr_issue_addr", 32'(E_ADDR), 32'h155);
        chk("wr_issue_dout", 32'(E_DOUT), 32'hA5);
        repeat (4) tick();
        chk("wr_hold_outs", 32'(outs()), 32'h85);
        E_ACK = 1'b1;
        tick();
        chk("wr_done_outs", 32'(outs()), 32'hA1);
        E_ACK = 1'b0;
        REQ0 = 1'b0;
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 11'h7FF;

        // Recovery gap: no grant for the following 9 cycles (8 gap + 1 idle)
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (outs() != 8'h00) bad++;
        end
        chk("gap_no_grant", 32'(bad), 32'd0);

        // Read from requester 1
        tick();
        chk("rd_issue_outs", 32'(outs()), 32'h42);
        chk("rd_issue_addr", 32'(E_ADDR), 32'h7FF);
        E_ACK = 1'b1; E_DIN = 8'h3C;
        tick();
        chk("rd_done_outs", 32'(outs()), 32'h50);
        chk("rd_done_rdata", 32'(RDATA), 32'h3C);
        E_ACK = 1'b0; REQ1 = 1'b0;
        tick();
        chk("rd_idle_outs", 32'(outs()), 32'h00);

        // Stray ACK while idle is ignored
        E_ACK = 1'b1; E_DIN = 8'hFF;
        tick();
        E_ACK = 1'b0;
        chk("stray_ack_rdata", 32'(RDATA), 32'h3C);
        chk("stray_ack_outs", 32'(outs()), 32'h00);

        // Both requesting reads continuously: grants alternate 0,1,0,1
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 11'h010;
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 11'h020;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_grant", 32'({GNT0, GNT1, E_RD}), (i % 2 == 0) ? 32'h5 : 32'h3);
            chk("rr_addr", 32'(E_ADDR), (i % 2 == 0) ? 32'h010 : 32'h020);
            repeat (3) tick();
            E_ACK = 1'b1; E_DIN = 8'h40 + 8'(i);
            tick();
            chk("rr_done", 32'({DONE0, DONE1, ERR}), (i % 2 == 0) ? 32'h4 : 32'h2);
            chk("rr_rdata", 32'(RDATA), 32'h40 + 32'(i));
            E_ACK = 1'b0;
            if (i == 3) begin
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
            tick();
        end

        // Write timeout: no ACK, strobe held 16 cycles
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 11'h0AA; WDATA0 = 8'h5A;
        tick();
        chk("tmo_issue_outs", 32'(outs()), 32'h85);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (!E_WR) bad++;
        end
        chk("tmo_strobe_held", 32'(bad), 32'd0);
        tick();
        chk("tmo_done_outs", 32'(outs()), 32'hA9);
        chk("tmo_rdata_kept", 32'(RDATA), 32'h43);
        REQ0 = 1'b0;
        tick();
        chk("tmo_err_cleared", 32'(outs()), 32'h00);
        repeat (8) tick();

        // ACK on the exact timeout cycle wins
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 11'h001;
        tick();
        chk("edge_issue_outs", 32'(outs()), 32'h42);
        repeat (15) tick();
        chk("edge_last_cycle", 32'(outs()), 32'h42);
        E_ACK = 1'b1; E_DIN = 8'h77;
        tick();
        chk("edge_done_outs", 32'(outs()), 32'h50);
        chk("edge_rdata", 32'(RDATA), 32'h77);
        E_ACK = 1'b0; REQ1 = 1'b0;
        tick();

        // Reset asserted mid-ISSUE
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 11'h300; WDATA1 = 8'hC3;
        tick();
        chk("rst_pre_outs", 32'(outs()), 32'h45);
        tick();
        #2;
        RESET = 1'b0;
        #1;
        chk("rst_async_outs", 32'(outs()), 32'h00);
        chk("rst_async_addr", 32'(E_ADDR), 32'h000);
        tick();
        chk("rst_no_done", 32'(outs()), 32'h00);
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 11'h111;
        REQ1 = 1'b1; WE1 = 1'b0;
        RESET = 1'b1;
        tick();
        chk("rst_tie_req0", 32'(outs()), 32'h82);

        chk("no_overlap", 32'(overlap), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
